// File: rtl/soda_pkg.sv
// Shared types and default pricing for the soda machine controller and display.
package soda_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHG_ON   = 2'd2,
        CHG_OFF  = 2'd3
    } state_t;

    localparam int SODA_PRICE = 55;
    localparam int SODA_UNIT  = 5;

endpackage

// File: rtl/soda_vend_ctrl_hold_timer.sv
// Down-counter that times how long the controller stays in a timed state.
// Loaded on the edge that enters the state; done marks the final cycle.
module hold_timer #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);
    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt;

    // Count down from HOLD-1 so the state lasts exactly HOLD cycles.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(HOLD - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/soda_vend_ctrl.sv
// Soda machine sequencing: coin credit, timed dispense pulse, change payout.
module soda_vend_ctrl
    import soda_pkg::*;
#(
    parameter int W     = 8,
    parameter int PRICE = SODA_PRICE,
    parameter int UNIT  = SODA_UNIT,
    parameter int HOLD  = 4
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         c,
    input  logic [W-1:0] a,
    input  logic         cancel,
    output logic [W-1:0] tot,
    output logic         d,
    output logic         change,
    output logic         coin_ack,
    output logic         coin_rej,
    output logic         busy
);
    localparam logic [W-1:0] PRICE_W = W'(PRICE);
    localparam logic [W-1:0] UNIT_W  = W'(UNIT);

    state_t       state;
    logic         c_q;
    logic         coin_ev;
    logic [W:0]   sum;
    logic         load;
    logic         done;

    assign coin_ev = c & ~c_q;
    assign sum     = {1'b0, tot} + {1'b0, a};

    // Timer reload whenever the FSM is about to change state.
    always_comb begin
        load = 1'b0;
        if (state == COLLECT)
            load = (cancel && tot >= UNIT_W) || (!coin_ev && tot >= PRICE_W);
        else
            load = done;
    end

    hold_timer #(.HOLD(HOLD)) u_timer (
        .clk   (sys_clk),
        .reset (reset),
        .load  (load),
        .done  (done)
    );

    // Main FSM; d/change/busy are registered alongside the state they mirror.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= COLLECT;
            tot      <= '0;
            c_q      <= 1'b0;
            d        <= 1'b0;
            change   <= 1'b0;
            coin_ack <= 1'b0;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
        end else begin
            c_q      <= c;
            coin_ack <= 1'b0;
            coin_rej <= 1'b0;
            case (state)
                COLLECT: begin
                    if (cancel && tot >= UNIT_W) begin
                        // Refund wins; a coin landing now is bounced.
                        coin_rej <= coin_ev;
                        state    <= CHG_ON;
                        change   <= 1'b1;
                        busy     <= 1'b1;
                    end else if (coin_ev) begin
                        if (!sum[W]) begin
                            tot      <= sum[W-1:0];
                            coin_ack <= 1'b1;
                        end else begin
                            coin_rej <= 1'b1;
                        end
                    end else if (tot >= PRICE_W) begin
                        tot   <= tot - PRICE_W;
                        state <= DISPENSE;
                        d     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                DISPENSE: begin
                    coin_rej <= coin_ev;
                    if (done) begin
                        d <= 1'b0;
                        if (tot >= UNIT_W) begin
                            state  <= CHG_ON;
                            change <= 1'b1;
                        end else begin
                            state <= COLLECT;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHG_ON: begin
                    coin_rej <= coin_ev;
                    if (done) begin
                        // Credit drops as the change pulse ends.
                        tot    <= tot - UNIT_W;
                        state  <= CHG_OFF;
                        change <= 1'b0;
                    end
                end
                CHG_OFF: begin
                    coin_rej <= coin_ev;
                    if (done) begin
                        if (tot >= UNIT_W) begin
                            state  <= CHG_ON;
                            change <= 1'b1;
                        end else begin
                            state <= COLLECT;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= COLLECT;
                    d      <= 1'b0;
                    change <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soda_vend_ctrl.sv
// Directed bench for soda_vend_ctrl: vector table plus hand-written refund/reset sequences.
module tb_soda_vend_ctrl;
    localparam int W = 8;

    logic         sys_clk = 1'b0;
    logic         reset   = 1'b0;
    logic         c       = 1'b0;
    logic [W-1:0] a       = '0;
    logic         cancel  = 1'b0;
    logic [W-1:0] tot;
    logic         d, change, coin_ack, coin_rej, busy;

    int checks = 0;
    int errors = 0;

    soda_vend_ctrl #(.W(W), .PRICE(55), .UNIT(5), .HOLD(4)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .c        (c),
        .a        (a),
        .cancel   (cancel),
        .tot      (tot),
        .d        (d),
        .change   (change),
        .coin_ack (coin_ack),
        .coin_rej (coin_rej),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic         c;
        logic [W-1:0] a;
        logic         can;
        logic         rst;
        int           n;
        logic [W-1:0] tot;
        logic         d, chg, ack, rej, busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic c_i, input int a_i, input logic can_i, input logic rst_i,
                                input int n_i, input int tot_i, input logic d_i, input logic chg_i,
                                input logic ack_i, input logic rej_i, input logic busy_i);
        vec_t v;
        v.c = c_i; v.a = W'(a_i); v.can = can_i; v.rst = rst_i; v.n = n_i;
        v.tot = W'(tot_i); v.d = d_i; v.chg = chg_i; v.ack = ack_i; v.rej = rej_i; v.busy = busy_i;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one active edge, sample 1 time unit later.
    task automatic step(input logic c_i, input int a_i, input logic can_i, input logic rst_i);
        c = c_i; a = W'(a_i); cancel = can_i; reset = rst_i;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int t, input logic d_e, input logic chg_e,
                           input logic ack_e, input logic rej_e, input logic busy_e);
        chk({tag, ".tot"},  tot,      t);
        chk({tag, ".d"},    d,        d_e);
        chk({tag, ".chg"},  change,   chg_e);
        chk({tag, ".ack"},  coin_ack, ack_e);
        chk({tag, ".rej"},  coin_rej, rej_e);
        chk({tag, ".busy"}, busy,     busy_e);
    endtask

    logic prev_chg;
    int   hi_len, lo_len, pulses, exp_tot;
    bit   d_seen;

    task automatic track();
        if (d) d_seen = 1'b1;
        if (change) begin
            if (!prev_chg) begin
                if (pulses > 0) chk($sformatf("refund.lo_len%0d", pulses), lo_len, 4);
                pulses++;
                hi_len = 1;
            end else hi_len++;
        end else begin
            if (prev_chg) begin
                chk($sformatf("refund.hi_len%0d", pulses), hi_len, 4);
                exp_tot -= 5;
                chk($sformatf("refund.tot%0d", pulses), tot, exp_tot);
                lo_len = 1;
            end else lo_len++;
        end
        prev_chg = change;
    endtask

    initial begin
        // Reset
        add(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        // 25+25+10: dispense, one change coin
        add(1, 25, 0, 0, 1, 25, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 25, 0, 0, 0, 0, 0);
        add(1, 25, 0, 0, 1, 50, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 50, 0, 0, 0, 0, 0);
        add(1, 10, 0, 0, 1, 60, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 4,  5, 1, 0, 0, 0, 1);
        add(0, 0,  0, 0, 4,  5, 0, 1, 0, 0, 1);
        add(0, 0,  0, 0, 4,  0, 0, 0, 0, 0, 1);
        add(0, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0);
        // Exact price, first coin held high 10 cycles
        add(1, 25, 0, 0, 1, 25, 0, 0, 1, 0, 0);
        add(1, 25, 0, 0, 9, 25, 0, 0, 0, 0, 0);
        add(0, 0,  0, 0, 1, 25, 0, 0, 0, 0, 0);
        add(1, 25, 0, 0, 1, 50, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 50, 0, 0, 0, 0, 0);
        add(1, 5,  0, 0, 1, 55, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 4,  0, 1, 0, 0, 0, 1);
        add(0, 0,  0, 0, 2,  0, 0, 0, 0, 0, 0);
        // 25+25+7: remainder 2 kept, then 53 buys a second soda
        add(1, 25, 0, 0, 1, 25, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 25, 0, 0, 0, 0, 0);
        add(1, 25, 0, 0, 1, 50, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 50, 0, 0, 0, 0, 0);
        add(1, 7,  0, 0, 1, 57, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 4,  2, 1, 0, 0, 0, 1);
        add(0, 0,  0, 0, 3,  2, 0, 0, 0, 0, 0);
        add(1, 53, 0, 0, 1, 55, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 4,  0, 1, 0, 0, 0, 1);
        add(0, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0);
        // Coin during dispense rejected; overflow coin rejected
        add(1, 25, 0, 0, 1, 25, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 25, 0, 0, 0, 0, 0);
        add(1, 25, 0, 0, 1, 50, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 50, 0, 0, 0, 0, 0);
        add(1, 10, 0, 0, 1, 60, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1,  5, 1, 0, 0, 0, 1);
        add(1, 10, 0, 0, 1,  5, 1, 0, 0, 1, 1);
        add(0, 0,  0, 0, 2,  5, 1, 0, 0, 0, 1);
        add(0, 0,  0, 0, 4,  5, 0, 1, 0, 0, 1);
        add(0, 0,  0, 0, 4,  0, 0, 0, 0, 0, 1);
        add(0, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(1, 10, 0, 0, 1, 10, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 10, 0, 0, 0, 0, 0);
        add(1, 250,0, 0, 1, 10, 0, 0, 0, 1, 0);
        add(0, 0,  0, 0, 1, 10, 0, 0, 0, 0, 0);
        add(1, 5,  0, 0, 1, 15, 0, 0, 1, 0, 0);
        add(0, 0,  0, 0, 1, 15, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].c, int'(tbl[i].a), tbl[i].can, tbl[i].rst);
                chk_all($sformatf("row%0d.%0d", i, k), int'(tbl[i].tot), tbl[i].d, tbl[i].chg,
                        tbl[i].ack, tbl[i].rej, tbl[i].busy);
            end
        end

        // Refund of 15 with a coin in the same cycle, reset during the 2nd change pulse
        step(1, 5, 1, 0);
        chk_all("cancel_coin", 15, 0, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            chk_all($sformatf("r15_on%0d", k), 15, 0, 1, 0, 0, 1);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            chk_all($sformatf("r15_off%0d", k), 10, 0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0);
        chk_all("r15_on2", 10, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk_all("mid_reset", 0, 0, 0, 0, 0, 0);
        step(1, 25, 0, 0);
        chk_all("post_reset_coin", 25, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0);

        // 25+5 then cancel: six change pulses, 30 down to 0, no dispense
        step(1, 5, 0, 0);
        chk_all("r30_coin", 30, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0);
        prev_chg = 1'b0; hi_len = 0; lo_len = 0; pulses = 0; exp_tot = 30; d_seen = 1'b0;
        step(0, 0, 1, 0);
        track();
        for (int k = 0; k < 80 && busy; k++) begin
            step(0, 0, 0, 0);
            track();
        end
        chk("refund.timeout_busy", busy, 0);
        chk("refund.pulses", pulses, 6);
        chk("refund.final_tot", tot, 0);
        chk("refund.d_seen", d_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
